// File: rtl/uart_rx_frame_ctrl.sv
// Frame receiver sitting behind a uart_rx: parses A5 / length / payload / checksum
// frames, buffers the payload and replays it downstream over a valid/ready port.
module uart_rx_frame_ctrl #(
  parameter int CLK_FREQ       = 27_000_000,
  parameter int BOUD_RATE      = 9600,
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 40 * (CLK_FREQ / BOUD_RATE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_available,
  output logic       rx_clear_available,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] frame_len,
  output logic       err_checksum,
  output logic       err_length,
  output logic       err_timeout,
  output logic       busy
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] HEADER    = 8'hA5;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_t;

  state_t           state;
  logic [7:0]       buffer [MAX_LEN];
  logic [7:0]       len;
  logic [7:0]       acc;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] next_rd;
  logic [TMR_W-1:0] timer;
  logic             consume;
  logic             in_frame;
  logic             timer_hit;

  // The cycle carrying the acknowledge pulse never consumes, so one byte is taken once.
  assign consume   = rx_available && !rx_clear_available && (state != DRAIN);
  assign in_frame  = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign timer_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign next_rd   = rd_idx + IDX_W'(1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rx_clear_available <= 1'b0;
      out_valid          <= 1'b0;
      out_last           <= 1'b0;
      out_data           <= '0;
      frame_len          <= '0;
      err_checksum       <= 1'b0;
      err_length         <= 1'b0;
      err_timeout        <= 1'b0;
      len                <= '0;
      acc                <= '0;
      wr_idx             <= '0;
      rd_idx             <= '0;
      timer              <= '0;
    end else begin
      rx_clear_available <= consume;
      err_checksum       <= 1'b0;
      err_length         <= 1'b0;
      err_timeout        <= 1'b0;

      if (consume) begin
        timer <= '0;
      end else if (in_frame) begin
        if (timer_hit) begin
          err_timeout <= 1'b1;
          state       <= IDLE;
          timer       <= '0;
        end else begin
          timer <= timer + TMR_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (consume && rx_data == HEADER) begin
            state <= LEN;
          end
        end

        LEN: begin
          if (consume) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              err_length <= 1'b1;
              state      <= IDLE;
            end else begin
              len    <= rx_data;
              acc    <= rx_data;
              wr_idx <= '0;
              state  <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (consume) begin
            acc    <= acc + rx_data;
            wr_idx <= wr_idx + IDX_W'(1);
            if (8'(wr_idx) == len - 8'd1) begin
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (consume) begin
            if (rx_data == acc) begin
              state     <= DRAIN;
              rd_idx    <= '0;
              out_valid <= 1'b1;
              out_data  <= buffer[0];
              out_last  <= (len == 8'd1);
              frame_len <= len;
            end else begin
              err_checksum <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        DRAIN: begin
          // Output registers only move on a transfer, so a stalled beat holds steady.
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              rd_idx   <= next_rd;
              out_data <= buffer[next_rd[AW-1:0]];
              out_last <= (8'(next_rd) == len - 8'd1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; it is always rewritten before being read.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && consume) begin
      buffer[wr_idx[AW-1:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: a frame-level byte-stream model predicts
// payload beats and error pulses; a monitor pops and compares as the DUT produces them.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT     = 100;
  localparam int SEND_BUDGET = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_available = 1'b0;
  logic       rx_clear_available;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic [7:0] frame_len;
  logic       err_checksum;
  logic       err_length;
  logic       err_timeout;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .CLK_FREQ      (27_000_000),
    .BOUD_RATE     (9600),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_available      (rx_available),
    .rx_clear_available(rx_clear_available),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .frame_len         (frame_len),
    .err_checksum      (err_checksum),
    .err_length        (err_length),
    .err_timeout       (err_timeout),
    .busy              (busy)
  );

  // kind: 0 payload beat, 1 length error, 2 checksum error, 3 timeout error
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    logic [7:0] flen;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fails = 0;
  int   ready_mode = 0;
  int   cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void push_exp(input int kind, input logic [7:0] data, input logic last, input logic [7:0] flen);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.last = last;
    e.flen = flen;
    expq.push_back(e);
  endfunction

  // Scans a byte stream starting from an idle receiver; returns 1 if it ends mid-frame.
  function automatic bit model_chunk(input logic [7:0] b[$]);
    int i = 0;
    int n = b.size();
    int len;
    int sum;
    while (i < n) begin
      if (b[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) begin
        push_exp(3, 8'h00, 1'b0, 8'h00);
        return 1'b1;
      end
      len = int'(b[i]);
      i++;
      if (len == 0 || len > MAX_LEN) begin
        push_exp(1, 8'h00, 1'b0, 8'h00);
        continue;
      end
      if (i + len + 1 > n) begin
        push_exp(3, 8'h00, 1'b0, 8'h00);
        return 1'b1;
      end
      sum = len;
      for (int k = 0; k < len; k++) sum += int'(b[i + k]);
      if ((sum % 256) == int'(b[i + len])) begin
        for (int k = 0; k < len; k++) push_exp(0, b[i + k], (k == len - 1), 8'(len));
      end else begin
        push_exp(2, 8'h00, 1'b0, 8'h00);
      end
      i += len + 1;
    end
    return 1'b0;
  endfunction

  // Behaves like uart_rx: holds the byte until acknowledged, drops the flag one cycle later.
  task automatic send_byte(input logic [7:0] v);
    int waited = 0;
    rx_data = v;
    rx_available = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_clear_available) break;
      waited++;
      if (waited > SEND_BUDGET) begin
        checkOutput("send_ack_timeout", 32'd0, 32'd1);
        rx_available = 1'b0;
        return;
      end
    end
    @(negedge clk);
    rx_available = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b[$]);
    bit incomplete;
    incomplete = model_chunk(b);
    foreach (b[k]) begin
      send_byte(b[k]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (incomplete) repeat (TIMEOUT + 10) @(negedge clk);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (expq.size() != 0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("scoreboard_drained", expq.size(), 0);
    repeat (2) @(negedge clk);
    checkOutput("busy_idle", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_rx_clear"}, rx_clear_available, 1'b0);
    checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_out_last"}, out_last, 1'b0);
    checkOutput({tag, "_out_data"}, out_data, 8'h00);
    checkOutput({tag, "_frame_len"}, frame_len, 8'h00);
    checkOutput({tag, "_errors"}, {err_timeout, err_checksum, err_length}, 3'b000);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_clear = 1'b0;
  logic       prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [2:0] prev_errs = 3'b000;
  int         last_clear = 0;
  int         last_beat = 0;
  bit         mid_frame = 1'b0;

  // Monitor samples just after the falling edge, where outputs and inputs are settled.
  initial begin
    exp_t       e;
    logic [2:0] errs;
    int         kind;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_clear = 1'b0;
        prev_errs  = 3'b000;
        mid_frame  = 1'b0;
        continue;
      end
      errs = {err_timeout, err_checksum, err_length};
      if (prev_errs != 3'b000) checkOutput("err_one_cycle", errs, 3'b000);
      if (errs != 3'b000) begin
        checkOutput("err_exclusive", $countones(errs), 1);
        kind = err_length ? 1 : (err_checksum ? 2 : 3);
        if (expq.size() == 0) begin
          checkOutput("unexpected_error", kind, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("error_kind", kind, e.kind);
          if (kind == 3) checkOutput("timeout_latency", cyc - last_clear, TIMEOUT);
        end
      end
      if (prev_clear) checkOutput("clear_one_cycle", rx_clear_available, 1'b0);
      if (rx_clear_available) begin
        checkOutput("no_ack_during_drain", prev_valid, 1'b0);
        last_clear = cyc;
      end
      if (prev_valid && !prev_ready) begin
        checkOutput("stall_valid", out_valid, 1'b1);
        checkOutput("stall_data", out_data, prev_data);
        checkOutput("stall_last", out_last, prev_last);
      end
      if (out_valid) checkOutput("busy_in_drain", busy, 1'b1);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_beat", out_data, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          checkOutput("beat_kind", 0, e.kind);
          checkOutput("beat_data", out_data, e.data);
          checkOutput("beat_last", out_last, e.last);
          checkOutput("beat_frame_len", frame_len, e.flen);
        end
        if (mid_frame && ready_mode == 0) checkOutput("beat_back_to_back", cyc - last_beat, 1);
        mid_frame = !out_last;
        last_beat = cyc;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_clear = rx_clear_available;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_errs  = errs;
    end
  end

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] chunk[$];
    int         items;
    int         typ;
    int         len;
    int         sum;
    int         keep;
    int         w;
    logic [7:0] frame[$];

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ready_mode = 0;
    chunk = '{8'hA5, 8'h03, 8'h41, 8'h42, 8'h43, 8'hC9};
    applyStimulus(chunk);
    wait_drain();

    chunk = '{8'hA5, 8'h03, 8'h41, 8'h42, 8'h43, 8'hC8};
    applyStimulus(chunk);
    wait_drain();

    chunk = '{8'h00, 8'hA5, 8'h11};
    applyStimulus(chunk);
    chunk = '{8'hA5, 8'h00};
    applyStimulus(chunk);
    wait_drain();

    chunk = '{8'hA5, 8'h02, 8'h55};
    applyStimulus(chunk);
    chunk = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    applyStimulus(chunk);
    wait_drain();

    ready_mode = 1;
    chunk = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4, 8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
    applyStimulus(chunk);
    wait_drain();

    // Reset asserted while the acknowledge pulse for a payload byte is high.
    ready_mode = 0;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h11);
    rx_data = 8'h22;
    rx_available = 1'b1;
    w = 0;
    while (!rx_clear_available && w < SEND_BUDGET) begin
      @(negedge clk);
      w++;
    end
    checkOutput("mid_payload_ack_seen", rx_clear_available, 1'b1);
    #2;
    rst_n = 1'b0;
    rx_available = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chunk = '{8'hA5, 8'h02, 8'h5A, 8'hA5, 8'h01};
    applyStimulus(chunk);
    wait_drain();

    for (int iter = 0; iter < 25; iter++) begin
      ready_mode = $urandom_range(0, 2);
      chunk = {};
      items = $urandom_range(1, 3);
      for (int it = 0; it < items; it++) begin
        typ = $urandom_range(0, 4);
        if (typ == 4 && it != items - 1) typ = 0;
        case (typ)
          0, 1, 4: begin
            len = $urandom_range(1, MAX_LEN);
            frame = '{8'hA5, 8'(len)};
            sum = len;
            for (int k = 0; k < len; k++) begin
              frame.push_back(8'($urandom_range(0, 255)));
              sum += int'(frame[k + 2]);
            end
            if (typ == 1) sum += $urandom_range(1, 255);
            frame.push_back(8'(sum));
            keep = (typ == 4) ? $urandom_range(1, len + 2) : frame.size();
            for (int k = 0; k < keep; k++) chunk.push_back(frame[k]);
          end
          2: begin
            chunk.push_back(8'hA5);
            chunk.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
          end
          default: chunk.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      applyStimulus(chunk);
      wait_drain();
    end

    checkOutput("final_queue_empty", expq.size(), 0);
    checkOutput("final_busy", busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 27_000_000: system clock frequency in Hz.
REQ-002 Parameter BOUD_RATE, default 9600: UART baud rate.
REQ-003 Parameter MAX_LEN, default 16: maximum payload bytes per frame (1..255).
REQ-004 Parameter TIMEOUT_CYCLES, default 40*(CLK_FREQ/BOUD_RATE): maximum idle clocks between bytes inside a frame.
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rx_data  in  8  received byte from uart_rx.
REQ-008 rx_available  in  1  uart_rx byte-held flag.
REQ-009 rx_clear_available  out  1  one-cycle pulse to uart_rx acknowledging the byte.
REQ-010 out_data  out  8  payload byte to downstream.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 out_last  out  1  high with the final payload byte.
REQ-014 frame_len  out  8  payload length of the frame being drained; stable while out_valid.
REQ-015 err_checksum, err_length, err_timeout  out  1 each  one-cycle error pulses.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Frame format: header 0xA5, length byte N, N payload bytes, checksum byte = (N + sum of payload) mod 256.
REQ-018 States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
REQ-019 Byte consume: in IDLE/LEN/PAYLOAD/CSUM, a cycle with rx_available=1 and rx_clear_available=0 latches rx_data; rx_clear_available is high exactly the next cycle; rx_available is ignored during that pulse cycle.
REQ-020 In DRAIN no byte is consumed; rx_clear_available stays 0 and uart_rx holds its byte.
REQ-021 IDLE: byte 0xA5 -> LEN; any other byte is consumed and discarded, state stays IDLE.
REQ-022 LEN: N=0 or N>MAX_LEN -> err_length pulse, IDLE; else store N, reset checksum accumulator to N, write index 0, -> PAYLOAD.
REQ-023 PAYLOAD: byte written to buffer[index], accumulator += byte (8-bit wrap), index++; after N-th byte -> CSUM.
REQ-024 CSUM: byte equal to accumulator -> DRAIN with read index 0; mismatch -> err_checksum pulse, IDLE, buffer discarded.
REQ-025 DRAIN: out_valid=1, out_data=buffer[read index], out_last=1 when read index = N-1; transfer on out_valid&out_ready advances read index; transfer with out_last -> IDLE, out_valid=0 next cycle.
REQ-026 out_data/out_last hold stable while out_valid=1 and out_ready=0.
REQ-027 Timeout counter clears on every consumed byte and on entry to LEN; in LEN/PAYLOAD/CSUM, counter reaching TIMEOUT_CYCLES -> err_timeout pulse, IDLE; counter frozen in IDLE and DRAIN.
REQ-028 Byte consume and timeout in the same cycle: byte wins, no error.
REQ-029 Error pulses are mutually exclusive and last exactly one clock.
REQ-030 Buffer is MAX_LEN x 8 storage; indices sized ceil(log2(MAX_LEN+1)) bits; no wrap within a frame.

Reset
REQ-031 rst_n=0 at any time, including mid-frame or mid-DRAIN, forces IDLE within the same cycle asynchronously.
REQ-032 Reset values: rx_clear_available=0, out_valid=0, out_last=0, out_data=0, frame_len=0, all error pulses=0, busy=0, counters and indices 0.
REQ-033 Buffer contents need no reset.

Verification
REQ-034 Good frame A5 03 41 42 43 C9, out_ready=1 -> out_data 41,42,43 on three consecutive cycles, out_last on 43, frame_len=3, no error, busy=0 afterwards.
REQ-035 Same frame with checksum C8 -> err_checksum single pulse after C8 consumed, out_valid never asserted, busy=0.
REQ-036 Bytes 00 A5 11 -> 00 discarded in IDLE, then err_length pulse on 0x11 (MAX_LEN=16); also A5 00 -> err_length.
REQ-037 A5 02 55, then line idle TIMEOUT_CYCLES (bench overrides TIMEOUT_CYCLES=100) -> err_timeout pulse at exactly 100 idle clocks, next A5 01 7F 80 accepted, out_data 7F.
REQ-038 Good frame with out_ready toggling 0/1 each cycle, next frame's A5 arriving during DRAIN -> payload stable while stalled, A5 not acknowledged until DRAIN ends, second frame received intact.
REQ-039 rst_n pulsed low mid-PAYLOAD -> all outputs at reset values immediately; following good frame decoded correctly; every rx_clear_available is exactly one cycle wide.
